// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake. Single-cycle ops finish at the launch edge;
// MUL (shift-add) and multi-bit shifts iterate one step per clock before reporting done.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mbr,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             busy,
  output logic             done
);

  localparam int SW  = $clog2(WIDTH);
  localparam int CW  = SW + 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   shReg;
  logic               shLeft;

  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     subDiff;
  logic [SW-1:0]      shAmt;
  logic               isMul;
  logic               isShift;
  logic [WIDTH-1:0]   opRes;
  logic               opC;
  logic               opV;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH-1:0]   shNext;
  logic               shOut;

  assign addSum  = {1'b0, acc} + {1'b0, mbr} + {{WIDTH{1'b0}}, cin};
  assign subDiff = {1'b0, acc} - {1'b0, mbr} - {{WIDTH{1'b0}}, cin};
  assign shAmt   = mbr[SW-1:0];
  assign isMul   = MUL_EN && (op == 4'b1001);
  assign isShift = ((op == 4'b1010) || (op == 4'b1011)) && (shAmt != '0);
  assign busy    = (state != S_IDLE);

  // Result of every operation that completes at the launch edge, including zero-length shifts.
  always_comb begin
    opRes = '0;
    opC   = 1'b0;
    opV   = 1'b0;
    case (op)
      4'b0000: opRes = mbr;
      4'b0001: begin
        opRes = addSum[MSB:0];
        opC   = addSum[WIDTH];
        opV   = (acc[MSB] == mbr[MSB]) && (addSum[MSB] != acc[MSB]);
      end
      4'b0010: opRes = ~acc;
      4'b0011: opRes = acc | mbr;
      4'b0100: opRes = acc & mbr;
      4'b0101: opRes = acc ^ mbr;
      4'b0110: begin
        opRes = {1'b0, acc[MSB:1]};
        opC   = acc[0];
      end
      4'b0111: begin
        opRes = {acc[MSB-1:0], 1'b0};
        opC   = acc[MSB];
      end
      4'b1000: begin
        opRes = subDiff[MSB:0];
        opC   = subDiff[WIDTH];
        opV   = (acc[MSB] != mbr[MSB]) && (subDiff[MSB] != acc[MSB]);
      end
      4'b1010, 4'b1011: opRes = acc;
      default: opRes = '0;
    endcase
  end

  // One shift-add step: the multiplier sits in the low half of prod and drains out to the right.
  always_comb begin
    mulSum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    mulNext = {mulSum, prod[WIDTH-1:1]};
  end

  always_comb begin
    if (shLeft) begin
      shNext = {shReg[MSB-1:0], 1'b0};
      shOut  = shReg[MSB];
    end else begin
      shNext = {1'b0, shReg[MSB:1]};
      shOut  = shReg[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mcand     <= '0;
      prod      <= '0;
      shReg     <= '0;
      shLeft    <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      c         <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
      v         <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (isMul) begin
              mcand <= acc;
              prod  <= {{WIDTH{1'b0}}, mbr};
              cnt   <= '0;
              state <= S_MUL;
            end else if (isShift) begin
              shReg  <= acc;
              shLeft <= ~op[0];
              cnt    <= {1'b0, shAmt};
              state  <= S_SHIFT;
            end else begin
              result    <= opRes;
              result_hi <= '0;
              c         <= opC;
              z         <= (opRes == '0);
              n         <= opRes[MSB];
              v         <= opV;
              done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod <= mulNext;
          cnt  <= cnt + CW'(1);
          if (cnt == MUL_LAST) begin
            result    <= mulNext[WIDTH-1:0];
            result_hi <= mulNext[2*WIDTH-1:WIDTH];
            c         <= (mulNext[2*WIDTH-1:WIDTH] != '0);
            z         <= (mulNext == '0);
            n         <= mulNext[2*WIDTH-1];
            v         <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_SHIFT: begin
          shReg <= shNext;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result    <= shNext;
            result_hi <= '0;
            c         <= shOut;
            z         <= (shNext == '0);
            n         <= shNext[MSB];
            v         <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: an arithmetic reference model with latency bookkeeping is
// compared every cycle, plus directed literal checks and a MUL_EN=0 instance.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] acc = '0;
  logic [W-1:0] mbr = '0;
  logic         cin = 1'b0;

  logic [W-1:0] result, resultHi;
  logic         c, z, n, v, busy, done;
  logic [W-1:0] result2, resultHi2;
  logic         c2, z2, n2, v2, busy2, done2;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  logic [W-1:0] expRes, expHi, pRes, pHi;
  logic         expC, expZ, expN, expV, expDone;
  logic         pC, pZ, pN, pV;
  int           remain, lat;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .acc(acc), .mbr(mbr), .cin(cin),
    .result(result), .result_hi(resultHi), .c(c), .z(z), .n(n), .v(v),
    .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dutNoMul (
    .clk(clk), .rst(rst), .start(start), .op(op), .acc(acc), .mbr(mbr), .cin(cin),
    .result(result2), .result_hi(resultHi2), .c(c2), .z(z2), .n(n2), .v(v2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour written from the opcode rules with plain integer arithmetic.
  function automatic void computeOp(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input bit mulEn,
                                    output logic [W-1:0] r, output logic [W-1:0] h,
                                    output logic fc, output logic fz, output logic fn,
                                    output logic fv, output int latency);
    int     t, sa, sb, s, k;
    longint p;
    bit     isMulOp;
    r = '0; h = '0; fc = 0; fz = 0; fn = 0; fv = 0; latency = 0; isMulOp = 0;
    sa = $signed(a);
    sb = $signed(b);
    k  = int'(b) % W;
    case (o)
      4'd0: r = b;
      4'd1: begin
        t = int'(a) + int'(b) + int'(ci);
        r = t[W-1:0];
        fc = (t >= (1 << W));
        s = sa + sb + int'(ci);
        fv = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
      end
      4'd2: r = ~a;
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: r = a ^ b;
      4'd6: begin r = a >> 1; fc = a[0]; end
      4'd7: begin r = a << 1; fc = a[W-1]; end
      4'd8: begin
        t = int'(a) - int'(b) - int'(ci);
        r = t[W-1:0];
        fc = (t < 0);
        s = sa - sb - int'(ci);
        fv = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
      end
      4'd9: begin
        if (mulEn) begin
          isMulOp = 1;
          p = longint'(a) * longint'(b);
          r = p[W-1:0];
          h = p[2*W-1:W];
          fc = (h != 0);
          fz = (p == 0);
          fn = h[W-1];
          latency = W;
        end
      end
      4'd10: begin r = a << k; fc = (k != 0) ? a[W-k] : 1'b0; latency = k; end
      4'd11: begin r = a >> k; fc = (k != 0) ? a[k-1] : 1'b0; latency = k; end
      default: r = '0;
    endcase
    if (!isMulOp) begin
      fz = (r == 0);
      fn = r[W-1];
    end
  endfunction

  // Model timeline: accept start only when idle, then report after the op's latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expRes = '0; expHi = '0; expC = 0; expZ = 0; expN = 0; expV = 0; expDone = 0; remain = 0;
    end else begin
      expDone = 0;
      if (remain == 0) begin
        if (start) begin
          computeOp(op, acc, mbr, cin, 1'b1, pRes, pHi, pC, pZ, pN, pV, lat);
          if (lat == 0) begin
            expRes = pRes; expHi = pHi; expC = pC; expZ = pZ; expN = pN; expV = pV; expDone = 1;
          end else begin
            remain = lat;
          end
        end
      end else begin
        remain--;
        if (remain == 0) begin
          expRes = pRes; expHi = pHi; expC = pC; expZ = pZ; expN = pN; expV = pV; expDone = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_result", result, expRes);
      checkOutput("model_result_hi", resultHi, expHi);
      checkOutput("model_flags_czn v", {c, z, n, v}, {expC, expZ, expN, expV});
      checkOutput("model_busy", busy, remain > 0);
      checkOutput("model_done", done, expDone);
    end
  end

  // Caller is at a negedge; the launch edge E0 is the next posedge.
  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    op = o; acc = a; mbr = b; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int maxCycles, output int busyCycles);
    int cycles;
    busyCycles = 0;
    cycles = 0;
    while (!done && cycles < maxCycles) begin
      if (busy) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_timeout: done=%0b required 1 within %0d cycles", name, done, maxCycles);
    end
  endtask

  initial begin
    int bc;
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    checkOutput("reset_result", result, 8'h00);
    checkOutput("reset_flags", {c, z, n, v, busy, done}, 6'b0);

    applyStimulus(4'b0001, 8'hFF, 8'h01, 1'b0);
    checkOutput("adc_ff_01_result", result, 8'h00);
    checkOutput("adc_ff_01_flags", {c, z, n, v}, 4'b1100);
    checkOutput("adc_ff_01_done_busy", {done, busy}, 2'b10);

    applyStimulus(4'b0001, 8'h7F, 8'h01, 1'b0);
    checkOutput("adc_7f_01_result", result, 8'h80);
    checkOutput("adc_7f_01_flags", {c, z, n, v}, 4'b0011);

    applyStimulus(4'b1000, 8'h00, 8'h01, 1'b0);
    checkOutput("sbb_00_01_result", result, 8'hFF);
    checkOutput("sbb_00_01_flags", {c, z, n, v}, 4'b1010);

    applyStimulus(4'b0010, 8'h5A, 8'h00, 1'b0);
    checkOutput("not_5a_result", result, 8'hA5);
    checkOutput("not_5a_carry", c, 1'b0);

    applyStimulus(4'b1001, 8'hFF, 8'hFF, 1'b0);
    waitDone("mul_ff_ff", 20, bc);
    checkOutput("mul_ff_ff_busy_cycles", bc, 8);
    checkOutput("mul_ff_ff_result", {resultHi, result}, 16'hFE01);
    checkOutput("mul_ff_ff_flags", {c, z, n, v, busy}, 5'b10100);

    applyStimulus(4'b1001, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    op = 4'b0000; mbr = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mul_ignored_start_busy", busy, 1'b1);
    waitDone("mul_12_34", 20, bc);
    checkOutput("mul_12_34_result", {resultHi, result}, 16'h03A8);
    @(negedge clk);
    checkOutput("mul_12_34_hold", result, 8'hA8);

    applyStimulus(4'b1010, 8'h21, 8'h03, 1'b0);
    waitDone("shln_21_3", 20, bc);
    checkOutput("shln_21_3_busy_cycles", bc, 3);
    checkOutput("shln_21_3_result", result, 8'h08);
    checkOutput("shln_21_3_carry", c, 1'b1);

    applyStimulus(4'b1011, 8'hC3, 8'h08, 1'b0);
    checkOutput("shrn_n0_result", result, 8'hC3);
    checkOutput("shrn_n0_done_carry", {done, c, busy}, 3'b100);

    applyStimulus(4'b1111, 8'h77, 8'h11, 1'b1);
    checkOutput("reserved_result", result, 8'h00);
    checkOutput("reserved_flags", {c, z, n, v, done}, 5'b01001);

    applyStimulus(4'b1001, 8'hFF, 8'hFF, 1'b0);
    checkOutput("nomul_reserved", {result2, resultHi2, c2, z2, n2, v2, busy2, done2}, {8'h00, 8'h00, 6'b010001});
    waitDone("mul_before_nomul_check", 20, bc);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'(i), 8'($urandom), 8'($urandom), 1'($urandom));
      waitDone("sweep", 20, bc);
    end

    applyStimulus(4'b1001, 8'h55, 8'h66, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 checkOutput("reset_mid_mul", {result, resultHi, c, z, n, v, busy, done}, 22'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checkOutput("no_done_after_abort", done, 1'b0);
    end
    applyStimulus(4'b0000, 8'h00, 8'h3C, 1'b0);
    checkOutput("mov_after_reset", {result, done}, {8'h3C, 1'b1});

    @(negedge clk);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
